alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Multi-cycle controller that fronts the 32-bit ALU datapath.
- Accepts one operation request at a time over a valid/ready handshake.
- Registers the operands and holds the ALU opcode stable for a per-operation settle time. Multiply and divide are treated as multicycle paths.
- Captures the 64-bit ALU result into a Z-style register and returns it over a valid/ready response channel.
- Sits between the control unit/testbench driver and the ALU instance.

Parameters:
- MUL_CYCLES, 4, settle cycles allowed for multiply before capture; must be >= 1.
- DIV_CYCLES, 8, settle cycles allowed for divide before capture; must be >= 1.
- CNT_W, $clog2(max(MUL_CYCLES,DIV_CYCLES)+1), latency counter width (derived).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_opcode  in  5  ALU opcode: 0 and, 1 or, 2 add, 3 sub, 4 mul, 5 div, 6 shr, 7 shra, 8 shl, 9 ror, 10 rol, 11 neg, 12 not.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- alu_a  out  32  registered operand to ALU A_reg.
- alu_b  out  32  registered operand to ALU B_reg.
- alu_opcode  out  5  registered opcode to ALU.
- alu_result  in  64  ALU out_result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_lo  out  32  Z[31:0]: result, or quotient for divide.
- rsp_hi  out  32  Z[63:32]: multiply upper half, or remainder for divide.
- rsp_err  out  1  illegal opcode or divide-by-zero.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (clear=0, asynchronous) values:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0.
  - rsp_lo, rsp_hi, alu_a, alu_b = 0.
  - alu_opcode=5'b11111, which drives the ALU default case and yields a zero result.
  - counter=0, busy=0.
- States:
  - IDLE: req_ready=1. On req_valid, register opcode/A/B onto alu_* and classify the request:
    - opcode > 12, or opcode=5 with req_b=0 → go to RESP. Z=0, rsp_err=1, alu_opcode stays 5'b11111.
    - opcode 4 → EXEC with counter=MUL_CYCLES-1.
    - opcode 5 → EXEC with counter=DIV_CYCLES-1.
    - any other legal opcode → EXEC with counter=0.
  - EXEC: alu_a, alu_b, alu_opcode held stable.
    - counter>0 → decrement.
    - counter=0 → Z<=alu_result, rsp_err<=0, go to RESP.
  - RESP: rsp_valid=1. rsp_lo, rsp_hi and rsp_err held stable until rsp_ready=1.
    - On rsp_ready=1 → go to IDLE and set alu_opcode=5'b11111.
    - alu_a and alu_b keep their last values.
- Latency, with the accept edge as T0:
  - Z captures at edge T0+L, where L = 1 for single-cycle ops, MUL_CYCLES for mul, DIV_CYCLES for div.
  - rsp_valid is high from the cycle after T0+L.
  - Error responses: rsp_valid is high from the cycle after T0.
- Throughput and handshake:
  - No overlap; req_ready=0 in EXEC and RESP.
  - The minimum request-to-request spacing for single-cycle ops is 3 cycles with rsp_ready held high.
  - req_valid while not ready is ignored and has no side effects.
  - Back-pressure: rsp_valid may stay high indefinitely; Z is never overwritten while in RESP.
- Result width: all 64 bits of alu_result are captured unmodified. Upper-half zeroing is the ALU's responsibility.
- Reset mid-operation: the in-flight op is dropped, no response is issued, and all outputs return to reset values immediately.
- busy = (state != IDLE).

Decomposition:
- Package alu_pkg:
  - opcode localparams (AND..NOT, OP_NOP=5'b11111);
  - state encoding IDLE/EXEC/RESP;
  - OP_MAX=12.
- Sub-module alu_lat_counter:
  - loadable down-counter (load, value, dec, zero);
  - instantiated once;
  - same clock/clear.
- FSM and Z register live in alu_sequencer.

Test Plan:
1. AND, A=0xF0F0_00FF, B=0x0FF0_0F0F, rsp_ready=1 → rsp_valid in cycle T0+2, rsp_lo=0x00F0_000F, rsp_hi=0, rsp_err=0.
2. MUL, A=0x0001_0000, B=0x0001_0000 (MUL_CYCLES=4) → alu_opcode stable for 4 EXEC cycles; rsp_valid first high at T0+5; rsp_hi=0x1, rsp_lo=0x0.
3. DIV, A=100, B=7 → rsp_lo=14, rsp_hi=2 after DIV_CYCLES. DIV, A=5, B=0 → rsp_err=1, rsp_lo=rsp_hi=0, rsp_valid at T0+1, ALU never sees opcode 5.
4. Illegal opcode 5'd20 → rsp_err=1, Z=0. Then ADD 3+4 → rsp_err=0, rsp_lo=7.
5. Back-pressure: ADD 1+1 with rsp_ready=0 for 10 cycles → rsp_valid and rsp_lo=2 stable; req_ready=0; a concurrent req_valid with a different opcode is ignored.
6. Reset mid-op: start DIV, drop clear low at EXEC cycle 3 → state IDLE, busy=0, rsp_valid never asserts. A following ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and request classification
// for the ALU sequencer.
package alu_pkg;

    localparam logic [4:0] OP_AND  = 5'd0;
    localparam logic [4:0] OP_OR   = 5'd1;
    localparam logic [4:0] OP_ADD  = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_MUL  = 5'd4;
    localparam logic [4:0] OP_DIV  = 5'd5;
    localparam logic [4:0] OP_SHR  = 5'd6;
    localparam logic [4:0] OP_SHRA = 5'd7;
    localparam logic [4:0] OP_SHL  = 5'd8;
    localparam logic [4:0] OP_ROR  = 5'd9;
    localparam logic [4:0] OP_ROL  = 5'd10;
    localparam logic [4:0] OP_NEG  = 5'd11;
    localparam logic [4:0] OP_NOT  = 5'd12;
    localparam logic [4:0] OP_MAX  = 5'd12;
    // Drives the ALU default case, which yields a zero result.
    localparam logic [4:0] OP_NOP  = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic req_is_error(input logic [4:0] op, input logic [31:0] b);
        return (op > OP_MAX) || ((op == OP_DIV) && (b == 32'd0));
    endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Loadable down-counter that times the ALU settle window.
module alu_lat_counter
    import alu_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins over decrement; never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (dec && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle request/response controller in front of the 32-bit ALU; holds
// operands stable for the opcode's settle time and captures the 64-bit result.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W = $clog2(((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1)
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_opcode,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_opcode,
    input  logic [63:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    output logic        rsp_err,
    output logic        busy
);

    state_e           state_q, state_d;
    logic [63:0]      z_q, z_d;
    logic             err_q, err_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [4:0]       op_q, op_d;
    logic             req_ready_q, rsp_valid_q, busy_q;
    logic             cnt_load_s, cnt_dec_s, cnt_zero_s;
    logic [CNT_W-1:0] cnt_val_s;

    alu_lat_counter #(.CNT_W(CNT_W)) u_lat (
        .clock (clock),
        .clear (clear),
        .load  (cnt_load_s),
        .value (cnt_val_s),
        .dec   (cnt_dec_s),
        .zero  (cnt_zero_s)
    );

    // Next-state, operand/opcode and Z register updates.
    always_comb begin
        state_d    = state_q;
        z_d        = z_q;
        err_d      = err_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        cnt_val_s  = {CNT_W{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    a_d = req_a;
                    b_d = req_b;
                    if (req_is_error(req_opcode, req_b)) begin
                        // Rejected requests never reach the ALU opcode port.
                        state_d = ST_RESP;
                        z_d     = 64'd0;
                        err_d   = 1'b1;
                        op_d    = OP_NOP;
                    end else begin
                        state_d    = ST_EXEC;
                        op_d       = req_opcode;
                        cnt_load_s = 1'b1;
                        if (req_opcode == OP_MUL) begin
                            cnt_val_s = CNT_W'(MUL_CYCLES - 1);
                        end else if (req_opcode == OP_DIV) begin
                            cnt_val_s = CNT_W'(DIV_CYCLES - 1);
                        end else begin
                            cnt_val_s = {CNT_W{1'b0}};
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_zero_s) begin
                    z_d     = alu_result;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    op_d    = OP_NOP;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                op_d    = OP_NOP;
            end
        endcase
    end

    // State, datapath and handshake registers; flags are decoded from state_d
    // so every output comes straight from a flop.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q     <= ST_IDLE;
            z_q         <= 64'd0;
            err_q       <= 1'b0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            op_q        <= OP_NOP;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            z_q         <= z_d;
            err_q       <= err_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            req_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign busy       = busy_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opcode = op_q;
    assign rsp_lo     = z_q[31:0];
    assign rsp_hi     = z_q[63:32];
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: ALU stub, transaction-level reference
// model compared every cycle, and directed vectors with literal expectations.
module tb_alu_sequencer;

    localparam int MUL_C = 4;
    localparam int DIV_C = 8;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_opcode = 5'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_opcode;
    logic [63:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_lo, rsp_hi;
    logic        rsp_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    alu_sequencer #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
        .clock(clock), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (op)
            5'd0:  return {32'd0, a & b};
            5'd1:  return {32'd0, a | b};
            5'd2:  return {32'd0, a + b};
            5'd3:  return {32'd0, a - b};
            5'd4:  return {32'd0, a} * {32'd0, b};
            5'd5:  return (b == 32'd0) ? 64'd0 : {a % b, a / b};
            5'd6:  return {32'd0, a >> s};
            5'd7:  return {32'd0, 32'($signed(a) >>> s)};
            5'd8:  return {32'd0, a << s};
            5'd9:  return {32'd0, (a >> s) | (a << (6'd32 - {1'b0, s}))};
            5'd10: return {32'd0, (a << s) | (a >> (6'd32 - {1'b0, s}))};
            5'd11: return {32'd0, -a};
            5'd12: return {32'd0, ~a};
            default: return 64'd0;
        endcase
    endfunction

    // ALU stand-in: combinational result from the registered ALU inputs.
    always_comb alu_result = alu_fn(alu_opcode, alu_a, alu_b);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: request accepted in idle; response appears L edges later.
    logic        m_ready = 1'b1, m_valid = 1'b0, m_busy = 1'b0, m_err = 1'b0;
    logic [63:0] m_z = 64'd0, m_pend = 64'd0;
    logic [31:0] m_a = 32'd0, m_b = 32'd0;
    logic [4:0]  m_op = 5'h1F;
    int          m_wait = 0;

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            m_ready <= 1'b1; m_valid <= 1'b0; m_busy <= 1'b0; m_err <= 1'b0;
            m_z <= 64'd0; m_a <= 32'd0; m_b <= 32'd0; m_op <= 5'h1F; m_wait <= 0;
        end else if (m_ready && req_valid) begin
            m_a <= req_a; m_b <= req_b; m_ready <= 1'b0; m_busy <= 1'b1;
            if (req_opcode > 5'd12 || (req_opcode == 5'd5 && req_b == 32'd0)) begin
                m_valid <= 1'b1; m_z <= 64'd0; m_err <= 1'b1; m_op <= 5'h1F;
            end else begin
                m_op   <= req_opcode;
                m_pend <= alu_fn(req_opcode, req_a, req_b);
                m_wait <= (req_opcode == 5'd4) ? MUL_C : (req_opcode == 5'd5) ? DIV_C : 1;
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_valid <= 1'b1; m_z <= m_pend; m_err <= 1'b0;
            end
        end else if (m_valid && rsp_ready) begin
            m_valid <= 1'b0; m_ready <= 1'b1; m_busy <= 1'b0; m_op <= 5'h1F;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("req_ready", {63'd0, req_ready}, {63'd0, m_ready});
            chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_valid});
            chk("busy", {63'd0, busy}, {63'd0, m_busy});
            chk("alu_opcode", {59'd0, alu_opcode}, {59'd0, m_op});
            chk("alu_ab", {alu_a, alu_b}, {m_a, m_b});
            chk("z", {rsp_hi, rsp_lo}, m_z);
            chk("rsp_err", {63'd0, rsp_err}, {63'd0, m_err});
        end
    end

    // Issue one request and measure edges from the accept edge to rsp_valid.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output bit op_stable);
        logic [4:0] exp_op;
        exp_op = (op > 5'd12 || (op == 5'd5 && b == 32'd0)) ? 5'h1F : op;
        req_opcode = op; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 0;
        op_stable = (alu_opcode == exp_op);
        while (!rsp_valid && lat < 60) begin
            @(posedge clock); #1;
            lat++;
            if (alu_opcode != exp_op) op_stable = 1'b0;
        end
        if (!rsp_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: rsp_valid never rose for opcode %0d", op);
        end
    endtask

    task automatic check_rsp(input string name, input int lat, input int lat_exp,
                             input logic [31:0] lo, input logic [31:0] hi, input logic err);
        chk({name, "_lat"}, 64'(lat), 64'(lat_exp));
        chk({name, "_lo"}, {32'd0, rsp_lo}, {32'd0, lo});
        chk({name, "_hi"}, {32'd0, rsp_hi}, {32'd0, hi});
        chk({name, "_err"}, {63'd0, rsp_err}, {63'd0, err});
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clock); #1;
    endtask

    int lat;
    bit stab;

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        chk("rst_z", {rsp_hi, rsp_lo}, 64'd0);
        chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);
        chk("rst_alu_opcode", {59'd0, alu_opcode}, 64'h1F);
        clear = 1'b1;
        chk_en = 1'b1;
        @(posedge clock); #1;

        issue(5'd0, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat, stab);
        check_rsp("and", lat, 1, 32'h00F0_000F, 32'd0, 1'b0);
        consume();

        issue(5'd4, 32'h0001_0000, 32'h0001_0000, lat, stab);
        check_rsp("mul", lat, MUL_C, 32'd0, 32'd1, 1'b0);
        chk("mul_op_stable", {63'd0, stab}, 64'd1);
        consume();

        issue(5'd5, 32'd100, 32'd7, lat, stab);
        check_rsp("div", lat, DIV_C, 32'd14, 32'd2, 1'b0);
        chk("div_op_stable", {63'd0, stab}, 64'd1);
        consume();

        issue(5'd5, 32'd5, 32'd0, lat, stab);
        check_rsp("div0", lat, 0, 32'd0, 32'd0, 1'b1);
        chk("div0_alu_nop", {63'd0, stab}, 64'd1);
        consume();

        issue(5'd20, 32'h1234_5678, 32'h9ABC_DEF0, lat, stab);
        check_rsp("illegal", lat, 0, 32'd0, 32'd0, 1'b1);
        consume();

        issue(5'd2, 32'd3, 32'd4, lat, stab);
        check_rsp("add", lat, 1, 32'd7, 32'd0, 1'b0);
        consume();

        issue(5'd3, 32'd3, 32'd4, lat, stab);
        check_rsp("sub", lat, 1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        consume();

        issue(5'd9, 32'h0000_00F1, 32'd4, lat, stab);
        check_rsp("ror", lat, 1, 32'h1000_000F, 32'd0, 1'b0);
        consume();

        rsp_ready = 1'b0;
        issue(5'd2, 32'd1, 32'd1, lat, stab);
        check_rsp("bp", lat, 1, 32'd2, 32'd0, 1'b0);
        req_opcode = 5'd3; req_a = 32'd9; req_b = 32'd5; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_lo", {32'd0, rsp_lo}, 64'd2);
            chk("bp_ready", {63'd0, req_ready}, 64'd0);
        end
        req_valid = 1'b0;
        consume();
        chk("bp_alu_a_kept", {32'd0, alu_a}, 64'd1);

        req_opcode = 5'd5; req_a = 32'd100; req_b = 32'd7; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;
        #1;
        chk("mrst_busy", {63'd0, busy}, 64'd0);
        chk("mrst_ready", {63'd0, req_ready}, 64'd1);
        chk("mrst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("mrst_opcode", {59'd0, alu_opcode}, 64'h1F);
        chk("mrst_alu_a", {32'd0, alu_a}, 64'd0);
        @(posedge clock); #3;
        clear = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            chk("mrst_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end

        issue(5'd2, 32'd10, 32'd20, lat, stab);
        check_rsp("post_add", lat, 1, 32'd30, 32'd0, 1'b0);
        consume();
        repeat (2) @(posedge clock);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
